// File: rtl/mic_pkg.sv
// mic_pkg: ADC frame constants, FSM state enum and shared helpers for the mic sampler.
package mic_pkg;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS = 4;
  localparam int DATA_BITS = 12;
  localparam logic [DATA_BITS-1:0] MIC_MID = 12'd2048;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, DONE} state_t;
  function automatic logic [DATA_BITS-1:0] max12(input logic [DATA_BITS-1:0] a, input logic [DATA_BITS-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/mic_if.sv
// mic_if: sample and peak-level bus from the mic sampler to its consumers.
interface mic_if;
  import mic_pkg::*;
  logic [DATA_BITS-1:0] sample;
  logic sample_valid;
  logic [DATA_BITS-1:0] peak;
  logic peak_valid;
  logic frame_err;
  modport master(output sample, sample_valid, peak, peak_valid, frame_err);
  modport slave(input sample, sample_valid, peak, peak_valid, frame_err);
endinterface

// File: rtl/mic_sampler_peak_hold.sv
// peak_hold: windowed maximum of a sample stream, reloaded every WINDOW samples.
module peak_hold
  import mic_pkg::*;
#(
  parameter int WINDOW = 4000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic [DATA_BITS-1:0] peak,
  output logic                 peak_valid
);
  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  logic [DATA_BITS-1:0] max_q, max_d, peak_q, peak_d, max_new;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pv_q, pv_d, last;
  always_comb begin
    max_new = max12(max_q, in_data);
    last = in_valid && (cnt_q == CNT_LAST);
    max_d = last ? '0 : in_valid ? max_new : max_q;
    cnt_d = last ? '0 : in_valid ? cnt_q + 1'b1 : cnt_q;
    peak_d = last ? max_new : peak_q;
    pv_d = last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      cnt_q <= '0;
      peak_q <= '0;
      pv_q <= 1'b0;
    end else begin
      max_q <= max_d;
      cnt_q <= cnt_d;
      peak_q <= peak_d;
      pv_q <= pv_d;
    end
  end
  assign peak = peak_q;
  assign peak_valid = pv_q;
endmodule

// File: rtl/mic_sampler.sv
// mic_sampler: SPI master polling a 12-bit ADC at a fixed rate, with windowed peak level.
module mic_sampler
  import mic_pkg::*;
#(
  parameter int CLK_DIV = 3,
  parameter int SAMPLE_PERIOD = 5000,
  parameter int PEAK_WINDOW = 4000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic miso,
  output logic cs_n,
  output logic sclk,
  mic_if.master mic
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PER_W = $clog2(SAMPLE_PERIOD);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  state_t state_q, state_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] smp_q, smp_d;
  logic cs_n_q, cs_n_d, sclk_q, sclk_d, sv_q, sv_d, fe_q, fe_d;
  logic start, phase_end;
  assign start = per_q == PER_LAST;
  assign phase_end = div_q == DIV_LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = start ? SETUP : IDLE;
      SETUP:    state_d = phase_end ? SHIFT_LO : SETUP;
      SHIFT_LO: state_d = phase_end ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: state_d = !phase_end ? SHIFT_HI : (bit_q == BIT_LAST) ? DONE : SHIFT_LO;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // Pins are registered from the state, so they trail it by one cycle and never glitch.
  always_comb begin
    cs_n_d = state_q inside {IDLE, DONE};
    sclk_d = state_q != SHIFT_LO;
    sv_d = state_q == DONE;
    fe_d = (state_q == DONE) && |sh_q[FRAME_BITS-1 -: LEAD_BITS];
    smp_d = (state_q == DONE) ? sh_q[DATA_BITS-1:0] : smp_q;
  end
  always_comb begin
    per_d = start ? '0 : per_q + 1'b1;
    div_d = (state_q inside {IDLE, DONE} || phase_end) ? '0 : div_q + 1'b1;
    sh_d = (state_q == SHIFT_HI && div_q == '0) ? {sh_q[FRAME_BITS-2:0], miso} : sh_q;
    bit_d = (state_q == IDLE) ? '0 : (state_q == SHIFT_HI && phase_end) ? bit_q + 1'b1 : bit_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q <= '0;
      div_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      smp_q <= '0;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b1;
      sv_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      per_q <= per_d;
      div_q <= div_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      smp_q <= smp_d;
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
      sv_q <= sv_d;
      fe_q <= fe_d;
    end
  end
  peak_hold #(.WINDOW(PEAK_WINDOW)) u_peak (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(sv_q),
    .in_data(smp_q),
    .peak(mic.peak),
    .peak_valid(mic.peak_valid)
  );
  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign mic.sample = smp_q;
  assign mic.sample_valid = sv_q;
  assign mic.frame_err = fe_q;
endmodule

// File: tb/tb_mic_sampler.sv
// tb_mic_sampler: directed frame table against a behavioural ADC, plus a mid-frame reset sequence.
module tb_mic_sampler;
  import mic_pkg::*;
  typedef struct {
    logic [15:0] word;
    logic [11:0] exp_sample;
    logic        exp_fe;
    logic        exp_pv;
    logic [11:0] exp_peak;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic miso = 1'b0;
  logic cs_n, sclk;
  logic [15:0] adc_word = 16'h0;
  logic [15:0] adc_sh = 16'h0;
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b1;
  int cs_low = 0;
  int rises = 0;
  int checks = 0;
  int errors = 0;
  vec_t vecs[24];
  mic_if mic();
  mic_sampler #(.CLK_DIV(1), .SAMPLE_PERIOD(40), .PEAK_WINDOW(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .miso(miso),
    .cs_n(cs_n),
    .sclk(sclk),
    .mic(mic)
  );
  always #5 clk = ~clk;
  // ADC model: load the word when cs_n falls, present the next bit on every sclk fall.
  always @(negedge cs_n or negedge sclk) begin
    if (sclk) adc_sh <= adc_word;
    else begin
      miso <= adc_sh[15];
      adc_sh <= {adc_sh[14:0], 1'b0};
    end
  end
  always @(negedge clk) begin
    if (prev_cs && !cs_n) begin
      cs_low <= 1;
      rises <= 0;
    end else if (!cs_n) begin
      cs_low <= cs_low + 1;
      if (!prev_sclk && sclk) rises <= rises + 1;
    end
    prev_cs <= cs_n;
    prev_sclk <= sclk;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_frame(input vec_t v, input int idx);
    int n;
    adc_word = v.word;
    n = 0;
    while (!mic.sample_valid && n < 120) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("sv_seen[%0d]", idx), n < 120, 1);
    if (n < 120) begin
      chk($sformatf("sample[%0d]", idx), mic.sample, v.exp_sample);
      chk($sformatf("frame_err[%0d]", idx), mic.frame_err, v.exp_fe);
      chk($sformatf("sclk_rises[%0d]", idx), rises, 16);
      chk($sformatf("cs_low[%0d]", idx), cs_low, 33);
      @(negedge clk);
      chk($sformatf("sv_width[%0d]", idx), mic.sample_valid, 0);
      chk($sformatf("fe_width[%0d]", idx), mic.frame_err, 0);
      chk($sformatf("peak_valid[%0d]", idx), mic.peak_valid, v.exp_pv);
      if (v.exp_pv) chk($sformatf("peak[%0d]", idx), mic.peak, v.exp_peak);
    end
  endtask
  initial begin
    int n;
    vecs[0]  = '{16'h0ABC, 12'hABC, 1'b0, 1'b0, 12'h000};
    vecs[1]  = '{16'h8ABC, 12'hABC, 1'b1, 1'b0, 12'h000};
    vecs[2]  = '{16'h0123, 12'h123, 1'b0, 1'b0, 12'h000};
    vecs[3]  = '{16'h0800, 12'h800, 1'b0, 1'b1, 12'hABC};
    vecs[4]  = '{16'h0900, 12'h900, 1'b0, 1'b0, 12'h000};
    vecs[5]  = '{16'h0F10, 12'hF10, 1'b0, 1'b0, 12'h000};
    vecs[6]  = '{16'h0850, 12'h850, 1'b0, 1'b0, 12'h000};
    vecs[7]  = '{16'h0800, 12'h800, 1'b0, 1'b1, 12'hF10};
    vecs[8]  = '{16'h0801, 12'h801, 1'b0, 1'b0, 12'h000};
    vecs[9]  = '{16'h0802, 12'h802, 1'b0, 1'b0, 12'h000};
    vecs[10] = '{16'h0803, 12'h803, 1'b0, 1'b0, 12'h000};
    vecs[11] = '{16'h0805, 12'h805, 1'b0, 1'b1, 12'h805};
    vecs[12] = '{16'h0100, 12'h100, 1'b0, 1'b0, 12'h000};
    vecs[13] = '{16'h0200, 12'h200, 1'b0, 1'b0, 12'h000};
    vecs[14] = '{16'h0300, 12'h300, 1'b0, 1'b0, 12'h000};
    vecs[15] = '{16'h0FFF, 12'hFFF, 1'b0, 1'b1, 12'hFFF};
    for (int i = 16; i < 24; i++) vecs[i] = '{16'hFFFF, 12'hFFF, 1'b1, (i % 4 == 3), 12'hFFF};
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_sample", mic.sample, 0);
    chk("rst_peak", mic.peak, 0);
    chk("rst_sv", mic.sample_valid, 0);
    chk("rst_pv", mic.peak_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) run_frame(vecs[i], i);
    adc_word = 16'h0555;
    n = 0;
    while (cs_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cs_fall_seen", n < 100, 1);
    repeat (15) @(negedge clk);
    chk("mid_cs_n", cs_n, 0);
    chk("mid_sclk", sclk, 0);
    chk("mid_sample", mic.sample, 12'hFFF);
    chk("mid_peak", mic.peak, 12'hFFF);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cs_n", cs_n, 1);
    chk("arst_sclk", sclk, 1);
    chk("arst_sample", mic.sample, 0);
    chk("arst_peak", mic.peak, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mic.sample_valid && n < 200);
    chk("rst_latency", n, 74);
    chk("post_rst_sample", mic.sample, 12'h555);
    chk("post_rst_fe", mic.frame_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
